// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: stall vectors,
// controller states and the default redirect address width.
package pipe_ctrl_pkg;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // One extra bit beyond the largest preload so the counter never wraps.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage stall vector, multi-cycle divide
// sequencing in EX, and flush/redirect on exceptions.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES   = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              div_start_i,
    input  logic              excp_valid_i,
    input  logic [ADDR_W-1:0] excp_pc_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic [ADDR_W-1:0] new_pc_o,
    output logic              div_busy_o,
    output logic              div_done_o
);

    localparam int CNT_W = cnt_width(DIV_CYCLES, FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flush_q, flush_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    logic              div_busy_q, div_busy_d;
    logic              div_done_q, div_done_d;
    logic [5:0]        req_stall;

    assign req_stall = stallreq_ex_i ? STALL_EX :
                       stallreq_id_i ? STALL_ID : STALL_NONE;

    // The down-counter serves both DIV and FLUSH since they never overlap.
    // The final DIV cycle (cnt==0) already behaves like IDLE for stalls, so
    // the pipeline is held exactly DIV_CYCLES cycles including the issue cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        flush_d    = 1'b0;
        new_pc_d   = new_pc_q;
        div_busy_d = 1'b0;
        div_done_d = 1'b0;
        stall_o    = STALL_NONE;

        case (state_q)
            ST_IDLE: begin
                stall_o = div_start_i ? STALL_EX : req_stall;
                if (div_start_i) begin
                    state_d    = ST_DIV;
                    cnt_d      = DIV_LOAD;
                    div_busy_d = 1'b1;
                    div_done_d = (DIV_LOAD == '0);
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    stall_o = req_stall;
                    state_d = ST_IDLE;
                end else begin
                    stall_o    = STALL_EX;
                    div_busy_d = 1'b1;
                    div_done_d = (cnt_q == CNT_ONE);
                    cnt_d      = cnt_q - CNT_ONE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_d = 1'b1;
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Exceptions pre-empt everything, including a divide in flight.
        if (excp_valid_i) begin
            state_d    = ST_FLUSH;
            cnt_d      = FLUSH_LOAD;
            flush_d    = 1'b1;
            new_pc_d   = excp_pc_i;
            div_busy_d = 1'b0;
            div_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            flush_q    <= 1'b0;
            new_pc_q   <= '0;
            div_busy_q <= 1'b0;
            div_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            flush_q    <= flush_d;
            new_pc_q   <= new_pc_d;
            div_busy_q <= div_busy_d;
            div_done_q <= div_done_d;
        end
    end

    assign flush_o    = flush_q;
    assign new_pc_o   = new_pc_q;
    assign div_busy_o = div_busy_q;
    assign div_done_o = div_done_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle-level event model plus directed
// vectors with hand-computed expectations (DIV_CYCLES=4, FLUSH_CYCLES=2).
module tb_pipe_ctrl;

    localparam int D = 4;
    localparam int F = 2;

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_ex, div_start, excp_valid;
    logic [31:0] excp_pc;
    logic [5:0]  stall;
    logic        flush, div_busy, div_done;
    logic [31:0] new_pc;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.DIV_CYCLES(D), .FLUSH_CYCLES(F), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id_i(stallreq_id),
        .stallreq_ex_i(stallreq_ex),
        .div_start_i  (div_start),
        .excp_valid_i (excp_valid),
        .excp_pc_i    (excp_pc),
        .stall_o      (stall),
        .flush_o      (flush),
        .new_pc_o     (new_pc),
        .div_busy_o   (div_busy),
        .div_done_o   (div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the falling edge.
    task automatic applyStimulus(input logic id, input logic ex, input logic ds,
                                 input logic ev, input logic [31:0] pc, input logic r = 1'b0);
        @(negedge clk);
        rst         = r;
        stallreq_id = id;
        stallreq_ex = ex;
        div_start   = ds;
        excp_valid  = ev;
        excp_pc     = pc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 32'h0);
    endtask

    // Event model: a divide issued at cycle s stalls s..s+D-1, is busy
    // s+1..s+D and completes at s+D; an exception at cycle e flushes
    // e+1..e+F. Cycle c is the window between a falling and rising edge.
    int          cyc = 0;
    bit          modelValid = 0;
    bit          divActive = 0;
    int          divStart = 0;
    int          flushEnd = -1;
    logic [31:0] expPc = '0;

    always @(negedge clk) begin
        bit          flushing;
        logic [5:0]  reqStall;
        logic [5:0]  expStall;
        #2;
        flushing = (cyc <= flushEnd);
        reqStall = stallreq_ex ? 6'b001111 : stallreq_id ? 6'b000111 : 6'b000000;
        if (flushing)
            expStall = 6'b000000;
        else if (divActive && cyc > divStart && cyc < divStart + D)
            expStall = 6'b001111;
        else if (divActive && cyc == divStart + D)
            expStall = reqStall;
        else
            expStall = div_start ? 6'b001111 : reqStall;

        if (modelValid) begin
            checkOutput("model_stall", {26'b0, stall}, {26'b0, expStall});
            checkOutput("model_flush", {31'b0, flush}, {31'b0, flushing});
            checkOutput("model_new_pc", new_pc, expPc);
            checkOutput("model_div_busy", {31'b0, div_busy},
                        {31'b0, divActive && cyc > divStart && cyc <= divStart + D});
            checkOutput("model_div_done", {31'b0, div_done},
                        {31'b0, divActive && cyc == divStart + D});
        end

        if (rst) begin
            divActive  = 0;
            flushEnd   = -1;
            expPc      = '0;
            modelValid = 1;
        end else if (excp_valid) begin
            divActive = 0;
            flushEnd  = cyc + F;
            expPc     = excp_pc;
        end else if (flushing) begin
        end else if (divActive) begin
            if (cyc == divStart + D) divActive = 0;
        end else if (div_start) begin
            divActive = 1;
            divStart  = cyc;
        end
        cyc++;
    end

    initial begin
        rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; div_start = 0; excp_valid = 0; excp_pc = '0;
        applyStimulus(0, 0, 0, 0, 32'h0, 1'b1);
        applyStimulus(0, 0, 0, 0, 32'h0, 1'b1);

        // Reset values
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3;
        checkOutput("reset_stall", {26'b0, stall}, 32'h0);
        checkOutput("reset_flush", {31'b0, flush}, 32'h0);
        checkOutput("reset_new_pc", new_pc, 32'h0);
        checkOutput("reset_busy", {31'b0, div_busy}, 32'h0);

        // ID interlock only for the cycle it is requested
        applyStimulus(1, 0, 0, 0, 32'h0);
        #3 checkOutput("id_stall", {26'b0, stall}, 32'h07);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("id_release", {26'b0, stall}, 32'h0);
        checkOutput("id_no_flush", {31'b0, flush}, 32'h0);

        // EX request dominates ID
        applyStimulus(1, 1, 0, 0, 32'h0);
        #3 checkOutput("ex_over_id", {26'b0, stall}, 32'h0F);
        applyStimulus(0, 1, 0, 0, 32'h0);
        #3 checkOutput("ex_only", {26'b0, stall}, 32'h0F);
        idle(1);

        // Full divide; ID request lands in the completion cycle
        applyStimulus(0, 0, 1, 0, 32'h0);
        #3 checkOutput("div_t0_stall", {26'b0, stall}, 32'h0F);
        checkOutput("div_t0_busy", {31'b0, div_busy}, 32'h0);
        applyStimulus(0, 0, 1, 0, 32'h0);
        #3 checkOutput("div_t1_busy", {31'b0, div_busy}, 32'h1);
        idle(2);
        #3 checkOutput("div_t3_stall", {26'b0, stall}, 32'h0F);
        checkOutput("div_t3_done", {31'b0, div_done}, 32'h0);
        applyStimulus(1, 0, 0, 0, 32'h0);
        #3 checkOutput("div_t4_done", {31'b0, div_done}, 32'h1);
        checkOutput("div_t4_busy", {31'b0, div_busy}, 32'h1);
        checkOutput("div_t4_stall", {26'b0, stall}, 32'h07);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("div_t5_done", {31'b0, div_done}, 32'h0);
        checkOutput("div_t5_busy", {31'b0, div_busy}, 32'h0);

        // Exception aborts a divide in flight
        applyStimulus(0, 0, 1, 0, 32'h0);
        idle(1);
        applyStimulus(0, 0, 0, 1, 32'hBFC00380);
        #3 checkOutput("abort_t2_stall", {26'b0, stall}, 32'h0F);
        applyStimulus(0, 1, 0, 0, 32'h0);
        #3 checkOutput("abort_t3_flush", {31'b0, flush}, 32'h1);
        checkOutput("abort_t3_pc", new_pc, 32'hBFC00380);
        checkOutput("abort_t3_stall", {26'b0, stall}, 32'h0);
        checkOutput("abort_t3_busy", {31'b0, div_busy}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("abort_t4_done", {31'b0, div_done}, 32'h0);
        checkOutput("abort_t4_flush", {31'b0, flush}, 32'h1);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("abort_t5_flush", {31'b0, flush}, 32'h0);
        checkOutput("abort_t5_done", {31'b0, div_done}, 32'h0);
        idle(2);

        // Second exception in first flush cycle restarts the flush
        applyStimulus(0, 0, 0, 1, 32'h12345678);
        applyStimulus(0, 0, 0, 1, 32'h80000180);
        #3 checkOutput("reflush_t1_pc", new_pc, 32'h12345678);
        applyStimulus(0, 1, 1, 0, 32'h0);
        #3 checkOutput("reflush_t2_pc", new_pc, 32'h80000180);
        checkOutput("reflush_t2_stall", {26'b0, stall}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("reflush_t3_flush", {31'b0, flush}, 32'h1);
        checkOutput("reflush_t3_busy", {31'b0, div_busy}, 32'h0);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("reflush_t4_flush", {31'b0, flush}, 32'h0);
        checkOutput("reflush_t4_pc", new_pc, 32'h80000180);

        // Simultaneous exception and divide start: exception wins
        applyStimulus(0, 0, 1, 1, 32'h00000100);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("tie_flush", {31'b0, flush}, 32'h1);
        checkOutput("tie_busy", {31'b0, div_busy}, 32'h0);
        idle(6);

        // Reset mid-divide, then a clean re-sequence
        applyStimulus(0, 0, 1, 0, 32'h0);
        idle(1);
        applyStimulus(0, 0, 0, 0, 32'h0, 1'b1);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("rst_busy", {31'b0, div_busy}, 32'h0);
        checkOutput("rst_stall", {26'b0, stall}, 32'h0);
        checkOutput("rst_pc", new_pc, 32'h0);
        applyStimulus(0, 0, 1, 0, 32'h0);
        idle(3);
        #3 checkOutput("redo_t3_stall", {26'b0, stall}, 32'h0F);
        applyStimulus(0, 0, 0, 0, 32'h0);
        #3 checkOutput("redo_t4_done", {31'b0, div_done}, 32'h1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
